// File: rtl/cpu_run_controller_if.sv
// rtl/cpu_run_controller_if.sv - Button, PC and run-control signals between board and cpu_run_controller
interface cpu_run_controller_if;
  logic        run_btn;
  logic        step_btn;
  logic        halt_btn;
  logic        init_btn;
  logic [14:0] pc;
  logic        cpu_en;
  logic        cpu_reset;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] cycle_count;

  modport master (
    output run_btn, step_btn, halt_btn, init_btn, pc,
    input  cpu_en, cpu_reset, state, halted, cycle_count
  );

  modport slave (
    input  run_btn, step_btn, halt_btn, init_btn, pc,
    output cpu_en, cpu_reset, state, halted, cycle_count
  );
endinterface

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - Run/step/halt sequencer for the Hack CPU with instruction counter,
// end-loop detector and optional instruction budget.
module cpu_run_controller #(
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned LOOP_REPEAT = 4,
  parameter int unsigned MAX_CYCLES  = 0
) (
  input logic                 clk,
  input logic                 reset,
  cpu_run_controller_if.slave bus
);
  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [7:0] RST_LAST   = 8'(RST_CYCLES);
  localparam logic [3:0] LOOP_LIMIT = 4'(LOOP_REPEAT);

  state_t      state_q;
  logic [3:0]  sync1_q, sync2_q, prev_q;
  logic [7:0]  rst_cnt_q;
  logic        cpu_en_q;
  logic        cpu_reset_q;
  logic [31:0] count_q;
  logic [14:0] pc_prev1_q, pc_prev2_q;
  logic [1:0]  pc_vld_q;
  logic [3:0]  conf_q;

  logic [3:0]  btn;
  logic [3:0]  pulse;
  logic [31:0] count_d;
  logic [3:0]  conf_d;
  logic        confirm;
  logic        auto_halt;

  // Button vectors are ordered {init, halt, step, run}, so bit index also gives priority.
  assign btn   = {bus.init_btn, bus.halt_btn, bus.step_btn, bus.run_btn};
  assign pulse = sync2_q & ~prev_q;

  assign count_d = (&count_q) ? count_q : count_q + 32'd1;

  // A two-instruction loop alternates, so the older PC only counts when the newer one differs.
  assign confirm = (pc_vld_q[0] && (bus.pc == pc_prev1_q)) ||
                   (pc_vld_q[1] && (bus.pc == pc_prev2_q));
  assign conf_d  = !confirm ? 4'd0 : ((conf_q == 4'hF) ? conf_q : conf_q + 4'd1);

  // Evaluated on the edge that retires the instruction, so that instruction is still counted.
  assign auto_halt = cpu_en_q &&
                     (((MAX_CYCLES != 0) && (count_d >= MAX_CYCLES)) || (conf_d >= LOOP_LIMIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RESET;
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      rst_cnt_q   <= '0;
      cpu_en_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
      count_q     <= '0;
      pc_prev1_q  <= '0;
      pc_prev2_q  <= '0;
      pc_vld_q    <= '0;
      conf_q      <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;

      if (cpu_en_q) begin
        count_q    <= count_d;
        conf_q     <= conf_d;
        pc_prev1_q <= bus.pc;
        pc_prev2_q <= pc_prev1_q;
        pc_vld_q   <= {pc_vld_q[0], 1'b1};
      end

      case (state_q)
        S_RESET: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q     <= S_IDLE;
            cpu_reset_q <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q + 8'd1;
          end
        end
        S_IDLE, S_HALT: begin
          // Re-reset loads 1: the entry edge itself is the first held cycle.
          if (pulse[3]) begin
            state_q     <= S_RESET;
            cpu_reset_q <= 1'b1;
            rst_cnt_q   <= 8'd1;
            count_q     <= '0;
            pc_vld_q    <= '0;
            conf_q      <= '0;
          end else if (pulse[2]) begin
            state_q <= S_HALT;
          end else if (pulse[1] || pulse[0]) begin
            state_q  <= pulse[1] ? S_STEP : S_RUN;
            cpu_en_q <= 1'b1;
            pc_vld_q <= '0;
            conf_q   <= '0;
          end
        end
        S_RUN: begin
          if (pulse[3]) begin
            state_q     <= S_RESET;
            cpu_reset_q <= 1'b1;
            cpu_en_q    <= 1'b0;
            rst_cnt_q   <= 8'd1;
            count_q     <= '0;
            pc_vld_q    <= '0;
            conf_q      <= '0;
          end else if (pulse[2] || auto_halt) begin
            state_q  <= S_HALT;
            cpu_en_q <= 1'b0;
          end
        end
        S_STEP: begin
          state_q  <= S_HALT;
          cpu_en_q <= 1'b0;
        end
        default: begin
          state_q     <= S_RESET;
          cpu_reset_q <= 1'b1;
          cpu_en_q    <= 1'b0;
          rst_cnt_q   <= 8'd1;
        end
      endcase
    end
  end

  assign bus.cpu_en      = cpu_en_q;
  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.state       = state_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.cycle_count = count_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - Directed bench for cpu_run_controller with a cycle-level reference model
module tb_cpu_run_controller;
  localparam int unsigned RST_CYCLES  = 4;
  localparam int unsigned LOOP_REPEAT = 4;
  localparam int unsigned MAX_CYCLES  = 100;

  localparam logic [2:0] M_RESET = 3'd0;
  localparam logic [2:0] M_IDLE  = 3'd1;
  localparam logic [2:0] M_RUN   = 3'd2;
  localparam logic [2:0] M_STEP  = 3'd3;
  localparam logic [2:0] M_HALT  = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'b0000;
  int         pc_idx = 0;
  int         pc_base = 0;
  bit         pc_loop = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         en_seen = 0;

  cpu_run_controller_if bus_if();

  cpu_run_controller #(
    .RST_CYCLES (RST_CYCLES),
    .LOOP_REPEAT(LOOP_REPEAT),
    .MAX_CYCLES (MAX_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // Program model: PC advances once per executed instruction.
  function automatic logic [14:0] pc_of(input int k, input bit loop);
    if (!loop || k <= 10) return k[14:0];
    return (k % 2 == 1) ? 15'd9 : 15'd10;
  endfunction

  always @(posedge clk) if (bus_if.cpu_en) pc_idx <= pc_idx + 1;

  assign bus_if.pc       = pc_of(pc_idx - pc_base, pc_loop);
  assign bus_if.run_btn  = btn[0];
  assign bus_if.step_btn = btn[1];
  assign bus_if.halt_btn = btn[2];
  assign bus_if.init_btn = btn[3];

  typedef struct packed {
    logic [2:0]  st;
    logic [8:0]  rst_left;
    logic        en;
    logic [32:0] cnt;
    logic [4:0]  conf;
    logic [1:0]  nh;
    logic [14:0] h1;
    logic [14:0] h2;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  s3;
  } model_t;

  model_t mdl;

  function automatic model_t reset_model();
    model_t m;
    m          = '0;
    m.st       = M_RESET;
    m.rst_left = 9'(RST_CYCLES + 1);
    return m;
  endfunction

  function automatic model_t mstep(input model_t m, input logic [3:0] b, input logic [14:0] pcv);
    model_t     n;
    logic [3:0] p;
    logic [2:0] ns;
    bit         conf_hit;
    bit         auto_h;
    n      = m;
    auto_h = 1'b0;
    p      = m.s2 & ~m.s3;
    n.s3   = m.s2;
    n.s2   = m.s1;
    n.s1   = b;
    if (m.en) begin
      if (m.cnt[31:0] != 32'hFFFF_FFFF) n.cnt = m.cnt + 33'd1;
      conf_hit = (m.nh >= 2'd1 && pcv == m.h1) || (m.nh >= 2'd2 && pcv == m.h2);
      n.conf   = !conf_hit ? 5'd0 : ((m.conf < 5'd15) ? m.conf + 5'd1 : 5'd15);
      n.h2     = m.h1;
      n.h1     = pcv;
      n.nh     = (m.nh < 2'd2) ? m.nh + 2'd1 : 2'd2;
      auto_h   = (m.st == M_RUN) &&
                 ((MAX_CYCLES != 0 && n.cnt >= 33'(MAX_CYCLES)) || n.conf >= 5'(LOOP_REPEAT));
    end
    ns = m.st;
    case (m.st)
      M_RESET: if (m.rst_left <= 9'd1) ns = M_IDLE; else n.rst_left = m.rst_left - 9'd1;
      M_IDLE, M_HALT: begin
        if (p[3]) ns = M_RESET;
        else if (p[2]) ns = M_HALT;
        else if (p[1]) ns = M_STEP;
        else if (p[0]) ns = M_RUN;
      end
      M_RUN: begin
        if (p[3]) ns = M_RESET;
        else if (p[2] || auto_h) ns = M_HALT;
      end
      default: ns = M_HALT;
    endcase
    if (ns == M_RESET && m.st != M_RESET) begin
      n.cnt      = '0;
      n.nh       = '0;
      n.conf     = '0;
      n.rst_left = 9'(RST_CYCLES);
    end
    if (m.st == M_HALT && (ns == M_RUN || ns == M_STEP)) begin
      n.nh   = '0;
      n.conf = '0;
    end
    n.st = ns;
    n.en = (ns == M_RUN) || (ns == M_STEP);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl <= reset_model();
    else        mdl <= mstep(mdl, btn, bus_if.pc);
  end

  task automatic cmp_loop();
    forever begin
      @(negedge clk);
      if (bus_if.cpu_en) en_seen++;
      n_tests++;
      if (bus_if.cpu_en !== mdl.en || bus_if.cpu_reset !== (mdl.st == M_RESET) ||
          bus_if.state !== mdl.st || bus_if.halted !== (mdl.st == M_HALT) ||
          bus_if.cycle_count !== mdl.cnt[31:0]) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: dut en=%0b rst=%0b st=%0d hlt=%0b cnt=%0d, required en=%0b rst=%0b st=%0d hlt=%0b cnt=%0d",
                 $time, bus_if.cpu_en, bus_if.cpu_reset, bus_if.state, bus_if.halted, bus_if.cycle_count,
                 mdl.en, (mdl.st == M_RESET), mdl.st, (mdl.st == M_HALT), mdl.cnt[31:0]);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic wait_st(input logic [2:0] s, input int lim, input string name);
    int k;
    k = 0;
    while (bus_if.state != s && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (bus_if.state != s) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: state %0d required %0d", name, bus_if.state, s);
    end
  endtask

  // Holds the buttons for three cycles; returns just after the resulting state change.
  task automatic press(input logic [3:0] mask);
    @(negedge clk);
    btn = mask;
    repeat (3) @(negedge clk);
    btn = 4'b0000;
  endtask

  initial begin
    int e0;
    int k;
    fork
      cmp_loop();
    join_none

    repeat (2) @(negedge clk);
    check("rst_state", 32'(bus_if.state), 0);
    check("rst_cpu_reset", 32'(bus_if.cpu_reset), 1);
    check("rst_cpu_en", 32'(bus_if.cpu_en), 0);
    check("rst_count", bus_if.cycle_count, 0);
    check("rst_halted", 32'(bus_if.halted), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_hold_state", 32'(bus_if.state), 0);
    check("rst_hold_cpu_reset", 32'(bus_if.cpu_reset), 1);
    @(negedge clk);
    check("idle_state", 32'(bus_if.state), 1);
    check("idle_cpu_reset", 32'(bus_if.cpu_reset), 0);

    for (int i = 0; i < 3; i++) begin
      press(4'b0010);
      if (i == 0) check("step_entry_en", 32'(bus_if.cpu_en), 1);
      repeat (4) @(negedge clk);
      check("step_state", 32'(bus_if.state), 4);
      check("step_halted", 32'(bus_if.halted), 1);
      check("step_count", bus_if.cycle_count, 32'(i + 1));
    end
    check("step_en_cycles", 32'(en_seen), 3);

    press(4'b1000);
    wait_st(M_IDLE, 20, "init_idle");
    check("init_count", bus_if.cycle_count, 0);

    pc_loop = 1'b1;
    pc_base = pc_idx;
    press(4'b0001);
    wait_st(M_HALT, 100, "loop_halt");
    check("loop_count", bus_if.cycle_count, 15);
    check("loop_halted", 32'(bus_if.halted), 1);
    press(4'b0001);
    check("loop_resume_run", 32'(bus_if.state), 2);
    wait_st(M_HALT, 100, "loop_rehalt");
    check("loop_resume_count", bus_if.cycle_count, 21);

    press(4'b1000);
    wait_st(M_IDLE, 20, "init2_idle");
    pc_loop = 1'b0;
    pc_base = pc_idx;
    e0      = en_seen;
    press(4'b0001);
    wait_st(M_HALT, 200, "budget_halt");
    check("budget_count", bus_if.cycle_count, 100);
    check("budget_en_cycles", 32'(en_seen - e0), 100);
    press(4'b0001);
    check("budget_resume_run", 32'(bus_if.state), 2);
    @(negedge clk);
    check("budget_resume_halt", 32'(bus_if.state), 4);
    check("budget_resume_count", bus_if.cycle_count, 101);

    press(4'b1000);
    wait_st(M_IDLE, 20, "init3_idle");
    press(4'b0001);
    repeat (5) @(negedge clk);
    press(4'b0101);
    check("prio_halt_over_run", 32'(bus_if.state), 4);
    press(4'b1010);
    check("prio_init_over_step", 32'(bus_if.state), 0);
    check("prio_init_cpu_reset", 32'(bus_if.cpu_reset), 1);
    check("prio_init_count", bus_if.cycle_count, 0);
    wait_st(M_IDLE, 20, "init4_idle");

    pc_base = pc_idx;
    press(4'b0001);
    k = 0;
    while (bus_if.cycle_count != 50 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("mid_count_50", bus_if.cycle_count, 50);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_cpu_en", 32'(bus_if.cpu_en), 0);
    check("mid_rst_cpu_reset", 32'(bus_if.cpu_reset), 1);
    check("mid_rst_count", bus_if.cycle_count, 0);
    check("mid_rst_state", 32'(bus_if.state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rel_hold", 32'(bus_if.state), 0);
    @(negedge clk);
    check("mid_rel_idle", 32'(bus_if.state), 1);
    check("mid_rel_cpu_reset", 32'(bus_if.cpu_reset), 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences execution of the Hack-style computer: generates the CPU clock-enable and CPU reset, and provides run / single-step / halt control from board buttons.
- Counts executed instructions and auto-halts on a programmed end loop or on a cycle budget.
- Sits between the board buttons and the computer top; `cpu_en` gates CPU, PC and data-memory write updates.

Parameters:
- RST_CYCLES, 4, number of cycles `cpu_reset` is held high after reset release or `init_btn`; legal range 1..255.
- LOOP_REPEAT, 4, consecutive loop confirmations needed before auto-halt; legal range 1..15.
- MAX_CYCLES, 0, executed-instruction budget; 0 disables the budget.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- run_btn  input  1  debounced level; rising edge starts/resumes free run
- step_btn  input  1  debounced level; rising edge executes one instruction
- halt_btn  input  1  debounced level; rising edge stops execution
- init_btn  input  1  debounced level; rising edge re-resets the CPU and clears the counter
- pc  input  15  current CPU program counter
- cpu_en  output  1  CPU clock-enable; high for one cycle per executed instruction
- cpu_reset  output  1  active-high reset to the CPU
- state  output  3  0 RESET_CPU, 1 IDLE, 2 RUN, 3 STEP, 4 HALT
- halted  output  1  high in HALT
- cycle_count  output  32  executed instructions, saturating at 2^32-1

Behaviour:
- Reset (`reset`=0, asynchronous): `state`=RESET_CPU, `cpu_reset`=1, `cpu_en`=0, `halted`=0, `cycle_count`=0, loop detector cleared, synchronizers cleared.
- Reset mid-operation: aborts immediately with no partial step. After release, the reset sequence restarts from the full RST_CYCLES.
- Button inputs:
  - Each button passes through a 2-flop synchronizer and then a rising-edge detector, giving a one-cycle pulse.
  - A button first sampled high at edge N changes `state` at edge N+2.
  - Holding a button causes no repeats.
- RESET_CPU:
  - `cpu_reset`=1 and `cpu_en`=0 for exactly RST_CYCLES cycles, then go to IDLE.
  - `cpu_reset` deasserts on the same edge the state becomes IDLE.
- IDLE:
  - `run` pulse -> RUN.
  - `step` pulse -> STEP.
  - `halt` pulse -> HALT.
  - `init` pulse -> RESET_CPU; the counter clears on entry.
- RUN: `cpu_en`=1 every cycle. `halt` or `init` pulse exits; `run` and `step` pulses are ignored.
- STEP: `cpu_en`=1 for exactly one cycle, then unconditionally -> HALT.
- HALT:
  - `cpu_en`=0 and `halted`=1.
  - `run` pulse -> RUN.
  - `step` pulse -> STEP.
  - `init` pulse -> RESET_CPU.
- Simultaneous pulses: priority is `init` > `halt` > `step` > `run`.
- Counter: increments on every cycle with `cpu_en`=1 and saturates at 0xFFFFFFFF. It clears only on entry to RESET_CPU.
- Budget (MAX_CYCLES>0):
  - In RUN, when the increment makes `cycle_count`==MAX_CYCLES, `cpu_en` goes low from the next cycle and `state` becomes HALT.
  - Exactly MAX_CYCLES instructions execute.
  - `run` from HALT afterwards re-enters RUN for one cycle, then halts again each cycle; the count keeps incrementing.
- Loop detector:
  - Sampled only on `cpu_en` cycles, using the `pc` value present during that cycle.
  - Keeps `pc_d1` and `pc_d2`, the previous two sampled values.
  - A confirmation is `pc`==`pc_d1` (self-jump), or `pc`==`pc_d2` with `pc`!=`pc_d1` (two-instruction `@END; 0;JMP` idiom).
  - A 4-bit confirmation counter increments on each confirmation and clears on any non-confirming sample.
  - When the counter reaches LOOP_REPEAT in RUN: -> HALT on the next edge, with `cpu_en` low from that edge.
  - The detector is cleared on entry to RESET_CPU and on every RUN/STEP entry from HALT, so resume is possible.
- STEP never triggers auto-halt, because it already ends in HALT; the detector still updates.
- Outputs are registered, except that `halted` is decoded from the `state` register.

Test Plan:
- Release reset with RST_CYCLES=4 -> `cpu_reset`=1 for 4 cycles, `state`=IDLE on the 5th edge, `cpu_en`=0, `cycle_count`=0.
- IDLE, pulse `step_btn` 3 times with gaps of ≥4 cycles -> exactly 3 one-cycle `cpu_en` pulses, `cycle_count`=3, `state`=HALT after each.
- RUN with a model PC sequence 0,1,2,...,9,10,9,10,9,10,... and LOOP_REPEAT=4 -> HALT after the 4th consecutive confirmation; `cycle_count`=15 (the halt-causing instruction counts); `halted`=1.
- MAX_CYCLES=100, PC incrementing -> exactly 100 `cpu_en` cycles, then HALT with `cycle_count`=100.
- Assert `halt_btn` and `run_btn` rising on the same cycle while in RUN -> HALT wins. Assert `init_btn` and `step_btn` together in HALT -> RESET_CPU, counter 0.
- Drop `reset` for one cycle during RUN at `cycle_count`=50 -> immediate `cpu_en`=0, `cpu_reset`=1, count 0. After release the full 4-cycle reset sequence runs, then IDLE.
